// File: rtl/fsm_job_requester_if.sv
// Control, worker handshake and status signals of the job requester.
// The requester uses the master view; the driving environment uses the slave view.
interface fsm_job_requester_if #(
  parameter int JOB_W = 8,
  parameter int LAT_W = 8
);
  logic             start;
  logic [JOB_W-1:0] num_jobs;
  logic             abort;
  logic             clear;
  logic             done_in;
  logic             go;
  logic             busy;
  logic [JOB_W-1:0] jobs_done;
  logic [LAT_W-1:0] last_latency;
  logic             all_done;
  logic             aborted;
  logic             timeout_err;
  logic             proto_err;

  modport master (
    input  start, num_jobs, abort, clear, done_in,
    output go, busy, jobs_done, last_latency, all_done, aborted, timeout_err, proto_err
  );

  modport slave (
    output start, num_jobs, abort, clear, done_in,
    input  go, busy, jobs_done, last_latency, all_done, aborted, timeout_err, proto_err
  );
endinterface

// File: rtl/fsm_job_requester.sv
// Issues one go pulse per job to a go/done worker, waits for each done, and reports
// progress, per-job latency, timeout and protocol errors. All outputs are Moore.
module fsm_job_requester #(
  parameter int JOB_W   = 8,
  parameter int LAT_W   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fsm_job_requester_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [JOB_W-1:0] r_remaining;
  logic [JOB_W-1:0] r_jobs_done;
  logic [JOB_W-1:0] w_rem_dec;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] r_last_lat;
  logic [LAT_W-1:0] w_lat_inc;
  logic             r_abort_latch;
  logic             r_aborted;
  logic             r_proto_err;
  logic             w_busy;
  logic             w_accept;
  logic             w_done_wait;
  logic             w_last_job;
  logic             w_abort_exit;

  assign w_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_FINISH);
  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_done_wait = (r_state == S_WAIT) && bus.done_in;
  assign w_rem_dec   = r_remaining - JOB_W'(1);
  assign w_last_job  = (w_rem_dec == '0);
  // Latency of the current WAIT cycle, saturating so a slow worker never wraps to 0.
  assign w_lat_inc   = (r_lat == '1) ? r_lat : r_lat + LAT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_abort_exit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = (bus.num_jobs == '0) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        // done wins over timeout; the in-flight job always completes before abort acts.
        if (bus.done_in) begin
          if (w_last_job) begin
            w_next_state = S_FINISH;
          end else if (r_abort_latch || bus.abort) begin
            w_next_state = S_IDLE;
            w_abort_exit = 1'b1;
          end else begin
            w_next_state = S_ISSUE;
          end
        end else if (w_lat_inc == LAT_W'(TIMEOUT)) begin
          w_next_state = S_ERROR;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      S_ERROR: begin
        if (bus.clear) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining   <= '0;
      r_jobs_done   <= '0;
      r_lat         <= '0;
      r_last_lat    <= '0;
      r_abort_latch <= 1'b0;
      r_aborted     <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_aborted <= w_abort_exit;

      if (w_busy && bus.abort) r_abort_latch <= 1'b1;

      if (w_accept) begin
        r_remaining   <= bus.num_jobs;
        r_jobs_done   <= '0;
        r_abort_latch <= 1'b0;
      end

      if (r_state == S_ISSUE)     r_lat <= '0;
      else if (r_state == S_WAIT) r_lat <= w_lat_inc;

      if (w_done_wait) begin
        r_last_lat  <= w_lat_inc;
        r_jobs_done <= r_jobs_done + JOB_W'(1);
        r_remaining <= w_rem_dec;
      end

      // A stray done in the same cycle as an accepted start still counts as an error.
      if (bus.done_in && (r_state != S_WAIT)) r_proto_err <= 1'b1;
      else if (w_accept)                      r_proto_err <= 1'b0;
    end
  end

  assign bus.go           = (r_state == S_ISSUE);
  assign bus.busy         = w_busy;
  assign bus.all_done     = (r_state == S_FINISH);
  assign bus.timeout_err  = (r_state == S_ERROR);
  assign bus.jobs_done    = r_jobs_done;
  assign bus.last_latency = r_last_lat;
  assign bus.aborted      = r_aborted;
  assign bus.proto_err    = r_proto_err;

endmodule

// File: tb/tb_fsm_job_requester.sv
// Bench for fsm_job_requester: a worker model with programmable latency, a cycle-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_fsm_job_requester;
  localparam int JOB_W   = 8;
  localparam int LAT_W   = 8;
  localparam int TIMEOUT = 32;
  localparam int LAT_MAX = (1 << LAT_W) - 1;
  localparam int JOB_MOD = 1 << JOB_W;

  localparam int M_IDLE   = 0;
  localparam int M_ISSUE  = 1;
  localparam int M_WAIT   = 2;
  localparam int M_FINISH = 3;
  localparam int M_ERROR  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fsm_job_requester_if #(.JOB_W(JOB_W), .LAT_W(LAT_W)) bus ();

  fsm_job_requester #(.JOB_W(JOB_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_checks   = 0;
  int   n_pass     = 0;
  int   cyc        = 0;
  int   worker_lat = 16;
  logic force_done = 1'b0;
  int   go_q[$];
  int   ad_q[$];
  int   ab_q[$];
  int   fall_q[$];
  int   te_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: batch bookkeeping in plain integers.
  int m_mode, m_rem, m_jobs, m_lat, m_last, m_abl, m_aborted, m_proto;

  task automatic m_reset();
    m_mode = M_IDLE; m_rem = 0; m_jobs = 0; m_lat = 0;
    m_last = 0; m_abl = 0; m_aborted = 0; m_proto = 0;
  endtask

  function automatic int m_busy();
    return (m_mode == M_ISSUE || m_mode == M_WAIT || m_mode == M_FINISH) ? 1 : 0;
  endfunction

  task automatic m_step();
    int prev;
    int dn;
    prev = m_mode;
    dn = int'(bus.done_in);
    m_aborted = 0;
    if (bus.abort && m_busy() == 1) m_abl = 1;
    case (m_mode)
      M_IDLE: if (bus.start) begin
        m_jobs = 0; m_proto = 0; m_abl = 0;
        if (bus.num_jobs == 0) m_mode = M_FINISH;
        else begin m_rem = int'(bus.num_jobs); m_mode = M_ISSUE; end
      end
      M_ISSUE: begin m_lat = 0; m_mode = M_WAIT; end
      M_WAIT: begin
        m_lat = (m_lat < LAT_MAX) ? m_lat + 1 : LAT_MAX;
        if (dn == 1) begin
          m_last = m_lat;
          m_jobs = (m_jobs + 1) % JOB_MOD;
          m_rem  = (m_rem + JOB_MOD - 1) % JOB_MOD;
          if (m_rem == 0)      m_mode = M_FINISH;
          else if (m_abl == 1) begin m_mode = M_IDLE; m_aborted = 1; end
          else                 m_mode = M_ISSUE;
        end else if (m_lat == TIMEOUT) m_mode = M_ERROR;
      end
      M_FINISH: m_mode = M_IDLE;
      default:  if (bus.clear) m_mode = M_IDLE;
    endcase
    if (dn == 1 && prev != M_WAIT) m_proto = 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // Worker: raises done in the worker_lat-th cycle after go; worker_lat=0 never answers.
  initial begin
    int cnt;
    logic d;
    cnt = -1;
    bus.done_in = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      d = 1'b0;
      if (!rst_n) cnt = -1;
      else if (bus.go) cnt = (worker_lat > 0) ? worker_lat : -1;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin d = 1'b1; cnt = -1; end
      end
      bus.done_in = d | force_done;
    end
  end

  // Per-cycle comparison against the model, plus event logging for directed checks.
  initial begin
    int prev_busy;
    int prev_te;
    prev_busy = 0;
    prev_te   = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      check("go",           int'(bus.go),           int'(m_mode == M_ISSUE));
      check("busy",         int'(bus.busy),         m_busy());
      check("all_done",     int'(bus.all_done),     int'(m_mode == M_FINISH));
      check("timeout_err",  int'(bus.timeout_err),  int'(m_mode == M_ERROR));
      check("jobs_done",    int'(bus.jobs_done),    m_jobs);
      check("last_latency", int'(bus.last_latency), m_last);
      check("aborted",      int'(bus.aborted),      m_aborted);
      check("proto_err",    int'(bus.proto_err),    m_proto);
      if (bus.go)       go_q.push_back(cyc);
      if (bus.all_done) ad_q.push_back(cyc);
      if (bus.aborted)  ab_q.push_back(cyc);
      if (prev_busy == 1 && !bus.busy) fall_q.push_back(cyc);
      if (prev_te == 0 && bus.timeout_err) te_q.push_back(cyc);
      prev_busy = int'(bus.busy);
      prev_te   = int'(bus.timeout_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    go_q.delete(); ad_q.delete(); ab_q.delete(); fall_q.delete(); te_q.delete();
  endtask

  task automatic start_batch(input int n);
    bus.start    = 1'b1;
    bus.num_jobs = JOB_W'(n);
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return go_q.size();
      1:       return ad_q.size();
      2:       return ab_q.size();
      default: return te_q.size();
    endcase
  endfunction

  task automatic wait_event(input int which, input int count, input int budget, input string name);
    for (int i = 0; i < budget && qsize(which) < count; i++) tick(1);
    check(name, int'(qsize(which) >= count), 1);
  endtask

  initial begin
    int drive;
    bus.start = 1'b0; bus.num_jobs = '0; bus.abort = 1'b0; bus.clear = 1'b0;

    // Reset state
    tick(3);
    check("rst_go", int'(bus.go), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_jobs_done", int'(bus.jobs_done), 0);
    check("rst_proto_err", int'(bus.proto_err), 0);
    rst_n = 1'b1;
    tick(2);

    // Three jobs against a 16-cycle worker
    worker_lat = 16;
    clear_q();
    start_batch(3);
    wait_event(1, 1, 200, "b3_all_done_seen");
    tick(3);
    check("b3_go_count", go_q.size(), 3);
    check("b3_last_latency", int'(bus.last_latency), 16);
    check("b3_jobs_done", int'(bus.jobs_done), 3);
    check("b3_all_done_count", ad_q.size(), 1);
    if (go_q.size() == 3 && ad_q.size() == 1 && fall_q.size() == 1) begin
      check("b3_gap01", go_q[1] - go_q[0], 17);
      check("b3_gap12", go_q[2] - go_q[1], 17);
      check("b3_all_done_cycle", ad_q[0] - go_q[2], 17);
      check("b3_busy_fall", fall_q[0] - ad_q[0], 1);
    end

    // Zero-job batch
    clear_q();
    drive = cyc;
    start_batch(0);
    tick(3);
    check("z_go_count", go_q.size(), 0);
    check("z_all_done_count", ad_q.size(), 1);
    if (ad_q.size() == 1) check("z_all_done_cycle", ad_q[0] - drive, 1);
    check("z_jobs_done", int'(bus.jobs_done), 0);

    // Worker never answers: timeout, start ignored, clear
    worker_lat = 0;
    clear_q();
    start_batch(1);
    wait_event(3, 1, 100, "to_error_seen");
    if (te_q.size() == 1 && go_q.size() == 1) check("to_cycle", te_q[0] - go_q[0], TIMEOUT + 1);
    check("to_timeout_err", int'(bus.timeout_err), 1);
    check("to_busy", int'(bus.busy), 0);
    start_batch(2);
    tick(3);
    check("to_start_ignored", go_q.size(), 1);
    check("to_still_err", int'(bus.timeout_err), 1);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(1);
    check("to_cleared", int'(bus.timeout_err), 0);
    check("to_idle_busy", int'(bus.busy), 0);

    // Abort during job 2
    worker_lat = 16;
    clear_q();
    start_batch(5);
    wait_event(0, 2, 100, "ab_second_go_seen");
    tick(5);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    wait_event(2, 1, 100, "ab_aborted_seen");
    tick(40);
    check("ab_aborted_count", ab_q.size(), 1);
    check("ab_go_count", go_q.size(), 2);
    check("ab_jobs_done", int'(bus.jobs_done), 2);
    check("ab_all_done_count", ad_q.size(), 0);
    check("ab_busy", int'(bus.busy), 0);

    // Stray done in IDLE, abort in IDLE, then a clean batch
    clear_q();
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    tick(2);
    check("pe_proto_err", int'(bus.proto_err), 1);
    check("pe_busy", int'(bus.busy), 0);
    check("pe_jobs_done", int'(bus.jobs_done), 2);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    start_batch(1);
    check("pe_cleared", int'(bus.proto_err), 0);
    wait_event(1, 1, 100, "pe_all_done_seen");
    tick(2);
    check("pe_aborted_count", ab_q.size(), 0);
    check("pe_jobs_done_after", int'(bus.jobs_done), 1);

    // Reset in the middle of job 1
    clear_q();
    start_batch(2);
    wait_event(0, 1, 50, "rs_go_seen");
    tick(4);
    rst_n = 1'b0;
    #1;
    check("rs_go", int'(bus.go), 0);
    check("rs_busy", int'(bus.busy), 0);
    check("rs_jobs_done", int'(bus.jobs_done), 0);
    check("rs_last_latency", int'(bus.last_latency), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_q();
    start_batch(2);
    wait_event(1, 1, 100, "rs_all_done_seen");
    tick(2);
    check("rs_go_count", go_q.size(), 2);
    check("rs_jobs_done_after", int'(bus.jobs_done), 2);
    check("rs_last_latency_after", int'(bus.last_latency), 16);

    // Maximum batch with a 1-cycle worker
    worker_lat = 1;
    clear_q();
    start_batch(JOB_MOD - 1);
    wait_event(1, 1, 1000, "mx_all_done_seen");
    tick(2);
    check("mx_jobs_done", int'(bus.jobs_done), JOB_MOD - 1);
    check("mx_go_count", go_q.size(), JOB_MOD - 1);
    check("mx_last_latency", int'(bus.last_latency), 1);
    check("mx_all_done_count", ad_q.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
